// File: rtl/strb_gen_mc.sv
// ---------------------------------------------------------------------------
// strb_gen_mc
//
// Multi-channel programmable strobe generator. Each of NCH channels is an
// independent IDLE/PHASE/RUN state machine. On launch, a channel captures its
// mode, period, phase and burst length. It waits out the phase delay and then
// emits single-cycle strobes spaced by the period. A channel runs until it is
// stopped (continuous mode) or until its strobe budget is used up (one-shot
// or burst mode). When the budget runs out it raises a one-cycle done pulse.
//
// Ports
//   clk        : clock, all logic on the rising edge
//   rst        : synchronous active-high reset
//   start      : [NCH]      per-channel launch request, honoured in IDLE only
//   stop       : [NCH]      per-channel abort, wins over start
//   mode       : [2*NCH]    0 continuous, 1 one-shot, 2 burst, 3 one-shot
//   period     : [CW*NCH]   strobe spacing in cycles (0 behaves as 1)
//   phase      : [CW*NCH]   delay before the first strobe
//   burst_len  : [BW*NCH]   strobe count in burst mode (0 behaves as 1)
//   strobe     : [NCH]      registered single-cycle strobe
//   busy       : [NCH]      registered, channel is in PHASE or RUN
//   done       : [NCH]      registered single-cycle natural-completion pulse
// ---------------------------------------------------------------------------
module strb_gen_mc #(
  parameter int NCH = 4,
  parameter int CW  = 16,
  parameter int BW  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    start,
  input  logic [NCH-1:0]    stop,
  input  logic [2*NCH-1:0]  mode,
  input  logic [CW*NCH-1:0] period,
  input  logic [CW*NCH-1:0] phase,
  input  logic [BW*NCH-1:0] burst_len,
  output logic [NCH-1:0]    strobe,
  output logic [NCH-1:0]    busy,
  output logic [NCH-1:0]    done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PHASE = 2'd1,
    RUN   = 2'd2
  } state_t;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    state_t          state, state_nx;
    logic [CW-1:0]   cnt, cnt_nx;
    logic [CW-1:0]   reload, reload_nx;
    logic [BW-1:0]   remain, remain_nx;
    logic            continuous, continuous_nx;
    logic            strobe_q, strobe_nx;
    logic            busy_q;
    logic            done_q, done_nx;

    logic [1:0]      cfg_mode;
    logic [CW-1:0]   cfg_period;
    logic [CW-1:0]   cfg_phase;
    logic [BW-1:0]   cfg_burst;

    assign cfg_mode   = mode[i*2 +: 2];
    assign cfg_period = period[i*CW +: CW];
    assign cfg_phase  = phase[i*CW +: CW];
    assign cfg_burst  = burst_len[i*BW +: BW];

    // A single down-counter serves both the phase delay and the period.
    // A strobe fires when it reads zero, so loading F gives the first strobe
    // F+1 edges after launch. Reloading P-1 then spaces strobes exactly P
    // apart. Both values fit in CW bits for every legal input, so the
    // counter never wraps.
    // 'remain' counts strobes still owed. Once it reaches zero in RUN, the
    // next edge retires the run with done, which gives the one-cycle gap
    // between the final strobe and done.
    always_comb begin
      state_nx      = state;
      cnt_nx        = cnt;
      reload_nx     = reload;
      remain_nx     = remain;
      continuous_nx = continuous;
      strobe_nx     = 1'b0;
      done_nx       = 1'b0;

      unique case (state)
        IDLE: begin
          if (start[i] && !stop[i]) begin
            state_nx      = PHASE;
            cnt_nx        = cfg_phase;
            reload_nx     = (cfg_period == '0) ? '0 : cfg_period - CW'(1);
            continuous_nx = (cfg_mode == 2'd0);
            if (cfg_mode == 2'd2)
              remain_nx = (cfg_burst == '0) ? BW'(1) : cfg_burst;
            else
              remain_nx = BW'(1);
          end
        end

        PHASE, RUN: begin
          if (stop[i]) begin
            state_nx = IDLE;
          end else if (state == RUN && !continuous && remain == '0) begin
            state_nx = IDLE;
            done_nx  = 1'b1;
          end else if (cnt == '0) begin
            strobe_nx = 1'b1;
            state_nx  = RUN;
            cnt_nx    = reload;
            if (!continuous)
              remain_nx = remain - BW'(1);
          end else begin
            cnt_nx = cnt - CW'(1);
          end
        end

        default: state_nx = IDLE;
      endcase
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        state      <= IDLE;
        cnt        <= '0;
        reload     <= '0;
        remain     <= '0;
        continuous <= 1'b0;
        strobe_q   <= 1'b0;
        busy_q     <= 1'b0;
        done_q     <= 1'b0;
      end else begin
        state      <= state_nx;
        cnt        <= cnt_nx;
        reload     <= reload_nx;
        remain     <= remain_nx;
        continuous <= continuous_nx;
        strobe_q   <= strobe_nx;
        busy_q     <= (state_nx != IDLE);
        done_q     <= done_nx;
      end
    end

    assign strobe[i] = strobe_q;
    assign busy[i]   = busy_q;
    assign done[i]   = done_q;
  end

endmodule

// File: tb/tb_strb_gen_mc.sv
// ---------------------------------------------------------------------------
// tb_strb_gen_mc
//
// Testbench for strb_gen_mc. It runs directed scenarios and then a long
// randomized section. Every edge is compared against a timeline model. The
// model does not track counters. It records the launch edge and the latched
// settings, and then works out from arithmetic whether a strobe, busy or done
// is expected at the current edge.
// ---------------------------------------------------------------------------
module tb_strb_gen_mc;
  localparam int NCH = 4;
  localparam int CW  = 16;
  localparam int BW  = 8;

  logic              clk;
  logic              rst;
  logic [NCH-1:0]    start;
  logic [NCH-1:0]    stop;
  logic [2*NCH-1:0]  mode;
  logic [CW*NCH-1:0] period;
  logic [CW*NCH-1:0] phase;
  logic [BW*NCH-1:0] burst_len;
  logic [NCH-1:0]    strobe;
  logic [NCH-1:0]    busy;
  logic [NCH-1:0]    done;

  strb_gen_mc #(.NCH(NCH), .CW(CW), .BW(BW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .mode      (mode),
    .period    (period),
    .phase     (phase),
    .burst_len (burst_len),
    .strobe    (strobe),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int edgeNum = 0;

  // Reference timeline per channel. bEff == 0 means the run never ends on
  // its own.
  bit act [NCH];
  int t0  [NCH];
  int fEff[NCH];
  int pEff[NCH];
  int bEff[NCH];

  logic [NCH-1:0] expStrobe;
  logic [NCH-1:0] expBusy;
  logic [NCH-1:0] expDone;

  task automatic checkOutput(input string tag, input logic [NCH-1:0] obs,
                             input logic [NCH-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s at edge %0d: got %b expected %b", tag, edgeNum, obs, exp);
    end
  endtask

  // Advance the model by one edge, using the inputs present at that edge.
  task automatic modelEdge();
    for (int c = 0; c < NCH; c++) begin
      int rel;
      int m;
      int p;
      int b;
      expStrobe[c] = 1'b0;
      expDone[c]   = 1'b0;
      if (rst) begin
        act[c] = 1'b0;
      end else if (act[c]) begin
        rel = edgeNum - t0[c] - 1 - fEff[c];
        if (stop[c]) begin
          act[c] = 1'b0;
        end else if (bEff[c] != 0 && rel == (bEff[c] - 1) * pEff[c] + 1) begin
          act[c]     = 1'b0;
          expDone[c] = 1'b1;
        end else if (rel >= 0 && (rel % pEff[c]) == 0) begin
          expStrobe[c] = 1'b1;
        end
      end else if (start[c] && !stop[c]) begin
        m       = int'(mode[c*2 +: 2]);
        p       = int'(period[c*CW +: CW]);
        b       = int'(burst_len[c*BW +: BW]);
        act[c]  = 1'b1;
        t0[c]   = edgeNum;
        fEff[c] = int'(phase[c*CW +: CW]);
        pEff[c] = (p == 0) ? 1 : p;
        if (m == 0)      bEff[c] = 0;
        else if (m == 2) bEff[c] = (b == 0) ? 1 : b;
        else             bEff[c] = 1;
      end
      expBusy[c] = act[c];
    end
  endtask

  task automatic setCfg(input int ch, input int m, input int p, input int f, input int b);
    mode[ch*2 +: 2]       = 2'(m);
    period[ch*CW +: CW]   = CW'(p);
    phase[ch*CW +: CW]    = CW'(f);
    burst_len[ch*BW +: BW] = BW'(b);
  endtask

  // Drive one cycle of control inputs, then compare all outputs after the edge.
  task automatic applyStimulus(input logic [NCH-1:0] st, input logic [NCH-1:0] sp,
                               input logic r);
    start = st;
    stop  = sp;
    rst   = r;
    @(posedge clk);
    modelEdge();
    edgeNum++;
    #1;
    checkOutput("strobe", strobe, expStrobe);
    checkOutput("busy", busy, expBusy);
    checkOutput("done", done, expDone);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus('0, '0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; start = '0; stop = '0;
    mode = '0; period = '0; phase = '0; burst_len = '0;
    for (int c = 0; c < NCH; c++) act[c] = 1'b0;

    // Reset state, then the first start at the first edge without reset.
    applyStimulus('0, '0, 1'b1);
    applyStimulus(4'hF, 4'hF, 1'b1);
    setCfg(0, 1, 3, 0, 0);
    applyStimulus(4'b0001, '0, 1'b0);
    idle(4);

    // Continuous channel 0, P=10, F=0.
    setCfg(0, 0, 10, 0, 0);
    applyStimulus(4'b0001, '0, 1'b0);
    idle(35);
    applyStimulus('0, 4'b0001, 1'b0);

    // Burst channel 1, P=4, F=3, B=3.
    setCfg(1, 2, 4, 3, 3);
    applyStimulus(4'b0010, '0, 1'b0);
    idle(16);

    // Degenerate channel 2, P=0, F=0, B=0.
    setCfg(2, 2, 0, 0, 0);
    applyStimulus(4'b0100, '0, 1'b0);
    idle(4);

    // Stop lands on the edge where the third strobe is due.
    setCfg(0, 0, 5, 0, 0);
    applyStimulus(4'b0001, '0, 1'b0);
    idle(10);
    applyStimulus('0, 4'b0001, 1'b0);
    idle(3);

    // Stop in IDLE alone does nothing.
    applyStimulus('0, 4'hF, 1'b0);

    // All channels at once. Start stays high, so it is ignored while busy
    // and relaunches the one-shot channel on the cycle done is high.
    setCfg(0, 0, 3, 0, 0);
    setCfg(1, 0, 4, 1, 0);
    setCfg(2, 0, 5, 2, 0);
    setCfg(3, 1, 6, 1, 0);
    for (int k = 0; k < 40; k++) applyStimulus(4'hF, '0, 1'b0);
    applyStimulus('0, 4'hF, 1'b0);

    // Reset in the middle of a long phase, then a fresh launch.
    setCfg(3, 0, 2, 100, 0);
    applyStimulus(4'b1000, '0, 1'b0);
    idle(50);
    applyStimulus('0, '0, 1'b1);
    setCfg(3, 2, 2, 2, 2);
    applyStimulus(4'b1000, '0, 1'b0);
    idle(10);

    // A longer phase and period checked over a full burst.
    setCfg(1, 2, 37, 300, 3);
    applyStimulus(4'b0010, '0, 1'b0);
    idle(420);

    // Randomized traffic. Config changes every cycle and must not disturb
    // channels that are already running.
    for (int k = 0; k < 3000; k++) begin
      logic [NCH-1:0] st;
      logic [NCH-1:0] sp;
      for (int c = 0; c < NCH; c++) begin
        setCfg(c, int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
               int'($urandom_range(0, 6)), int'($urandom_range(0, 5)));
        st[c] = ($urandom_range(0, 3) == 0);
        sp[c] = ($urandom_range(0, 31) == 0);
      end
      applyStimulus(st, sp, ($urandom_range(0, 499) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
